// File: rtl/req_pend_pkg.sv
// Shared constants, types and helpers for the request-pending arbiter.
package req_pend_pkg;

  localparam int DEF_N     = 4;
  localparam int DEF_CNT_W = 3;

  // Pending counts of all sources at the default geometry
  typedef logic [DEF_N-1:0][DEF_CNT_W-1:0] cnt_vec_t;

  // Output register state: EMPTY has no grant on offer, HOLD presents one
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } out_state_e;

  // Largest value a pending counter of width w can hold
  function automatic int cnt_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/req_pend_arb_if.sv
// Grant handshake between the arbiter (master) and the stalling consumer (slave).
interface req_pend_arb_if #(
  parameter int N = 4
);

  localparam int OUT_W = $clog2(N);

  logic             gnt_valid_o;
  logic [OUT_W-1:0] gnt_id_o;
  logic             gnt_ready_i;

  modport master (
    output gnt_valid_o,
    output gnt_id_o,
    input  gnt_ready_i
  );

  modport slave (
    input  gnt_valid_o,
    input  gnt_id_o,
    output gnt_ready_i
  );

endinterface

// File: rtl/req_pend_arb_pick.sv
// Highest-index-wins encoder over the pending bit vector.
module req_pick #(
  parameter int N     = 4,
  parameter int OUT_W = $clog2(N)
) (
  input  logic [N-1:0]     pend,
  output logic [OUT_W-1:0] id,
  output logic             any
);

  // Scan upward so the last set bit seen, the highest index, is kept
  always_comb begin
    id  = '0;
    any = |pend;
    for (int k = 0; k < N; k++) begin
      if (pend[k]) id = OUT_W'(k);
    end
  end

endmodule

// File: rtl/req_pend_arb.sv
// Collects request pulses into saturating per-source counters and offers the
// highest pending source as a registered valid/ready grant.
module req_pend_arb
  import req_pend_pkg::*;
#(
  parameter int N     = DEF_N,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic [N-1:0]  req_i,
  input  logic          ovf_clr_i,
  output logic [N-1:0]  pend_o,
  output logic [N-1:0]  ovf_o,
  req_pend_arb_if.master gnt
);

  localparam int OUT_W = $clog2(N);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  out_state_e       state;
  logic [OUT_W-1:0] id_q;
  logic [N-1:0]     pend;
  logic [OUT_W-1:0] pick;
  logic             any;
  logic             load;

  // Pick only looks at registered counts, so a request needs a cycle to be seen
  req_pick #(
    .N     (N),
    .OUT_W (OUT_W)
  ) u_pick (
    .pend (pend),
    .id   (pick),
    .any  (any)
  );

  assign load = any & ((state == EMPTY) | gnt.gnt_ready_i) & ~flush_i;

  for (genvar k = 0; k < N; k++) begin : g_src
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             inc;
    logic             dec;

    assign inc     = req_i[k];
    assign dec     = load & (pick == OUT_W'(k));
    assign pend[k] = (cnt != '0);
    assign ovf_o[k] = ovf;

    // Pending counter: a simultaneous request and grant cancel out, even when full
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (flush_i) begin
        cnt <= '0;
      end else if (inc && !dec && cnt != CNT_MAX) begin
        cnt <= cnt + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt <= cnt - CNT_W'(1);
      end
    end

    // Sticky overflow: a request dropped at saturation beats a same-cycle clear
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ovf <= 1'b0;
      end else if (!flush_i && inc && !dec && cnt == CNT_MAX) begin
        ovf <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf <= 1'b0;
      end
    end
  end

  // Output register FSM: HOLD keeps the id stable until the consumer accepts it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      id_q  <= '0;
    end else if (flush_i) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (any) begin
            state <= HOLD;
            id_q  <= pick;
          end
        end
        HOLD: begin
          if (gnt.gnt_ready_i) begin
            if (any) id_q <= pick;
            else     state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign pend_o          = pend;
  assign gnt.gnt_valid_o = (state == HOLD);
  assign gnt.gnt_id_o    = id_q;

endmodule
